// File: rtl/multiplicador_if.sv
// rtl/multiplicador_if.sv - operand/result handshake bundle for the shift-add multiplier
interface multiplicador_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               ready;
    logic               ack;
    logic               busy;
    logic               done_flag;
    logic [2*WIDTH-1:0] producto;

    modport master (
        output a, b, signed_mode, ready, ack,
        input  busy, done_flag, producto
    );

    modport slave (
        input  a, b, signed_mode, ready, ack,
        output busy, done_flag, producto
    );
endinterface

// File: rtl/multiplicador_param.sv
// rtl/multiplicador_param.sv - radix-2 sequential shift-add multiplier with signed mode and early exit
module multiplicador_param #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    multiplicador_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      step;
    logic               sign;
    logic               last_step;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Magnitudes stay WIDTH-bit unsigned so the most negative operand is represented exactly.
    always_comb begin
        a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        last_step = EARLY_EXIT ? (mplier[WIDTH-1:1] == '0)
                               : (step == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done_flag <= 1'b0;
            bus.producto  <= '0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            step          <= '0;
            sign          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ready) begin
                        mcand    <= {{WIDTH{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        acc      <= '0;
                        step     <= '0;
                        sign     <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + CW'(1);
                    // The final partial product is folded in on the same edge that publishes the result.
                    if (last_step) begin
                        bus.producto  <= sign ? -acc_next : acc_next;
                        bus.done_flag <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        bus.done_flag <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplicador_param.sv
// tb/tb_multiplicador_param.sv - self-checking bench for multiplicador_param (fixed-length and early-exit instances)
module tb_multiplicador_param;
    logic clk;
    logic reset;

    logic [15:0] a_r   [2];
    logic [15:0] b_r   [2];
    logic        sm_r  [2];
    logic        rdy_r [2];
    logic        ack_r [2];
    logic        busy_w[2];
    logic        done_w[2];
    logic [31:0] prod_w[2];

    int n_checks = 0;
    int n_errors = 0;

    multiplicador_if #(.WIDTH(16)) if0 ();
    multiplicador_if #(.WIDTH(16)) if1 ();

    assign if0.a = a_r[0];  assign if0.b = b_r[0];  assign if0.signed_mode = sm_r[0];
    assign if0.ready = rdy_r[0];  assign if0.ack = ack_r[0];
    assign if1.a = a_r[1];  assign if1.b = b_r[1];  assign if1.signed_mode = sm_r[1];
    assign if1.ready = rdy_r[1];  assign if1.ack = ack_r[1];
    assign busy_w[0] = if0.busy;  assign done_w[0] = if0.done_flag;  assign prod_w[0] = if0.producto;
    assign busy_w[1] = if1.busy;  assign done_w[1] = if1.done_flag;  assign prod_w[1] = if1.producto;

    multiplicador_param #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    multiplicador_param #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic sm);
        longint pa, pb;
        pa = sm ? longint'($signed(a)) : longint'(a);
        pb = sm ? longint'($signed(b)) : longint'(b);
        return 32'(pa * pb);
    endfunction

    function automatic int ref_steps(input logic [15:0] b, input logic sm, input bit early);
        logic [15:0] m;
        m = (sm && b[15]) ? -b : b;
        if (!early) return 16;
        for (int i = 15; i >= 0; i--)
            if (m[i]) return i + 1;
        return 1;
    endfunction

    // Transaction-level model: product and step count from arithmetic, plus a countdown.
    logic        m_busy[2] = '{1'b0, 1'b0};
    logic        m_done[2] = '{1'b0, 1'b0};
    logic [31:0] m_prod[2] = '{32'd0, 32'd0};
    logic [31:0] m_pend[2] = '{32'd0, 32'd0};
    int          m_rem [2] = '{0, 0};
    bit          cmp_en = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_prod[k] = 32'd0; m_rem[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_busy[k]) begin
                    if (rdy_r[k]) begin
                        m_busy[k] = 1'b1;
                        m_rem[k]  = ref_steps(b_r[k], sm_r[k], k == 1);
                        m_pend[k] = ref_prod(a_r[k], b_r[k], sm_r[k]);
                    end
                end else if (!m_done[k]) begin
                    m_rem[k] = m_rem[k] - 1;
                    if (m_rem[k] == 0) begin
                        m_done[k] = 1'b1;
                        m_prod[k] = m_pend[k];
                    end
                end else if (ack_r[k]) begin
                    m_done[k] = 1'b0;
                    m_busy[k] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cmp%0d busy", k), 64'(busy_w[k]), 64'(m_busy[k]));
                chk($sformatf("cmp%0d done", k), 64'(done_w[k]), 64'(m_done[k]));
                chk($sformatf("cmp%0d producto", k), 64'(prod_w[k]), 64'(m_prod[k]));
            end
        end
    end

    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic sm,
                          input logic [31:0] lit, input int edges, input string nm, input bit do_ack);
        int cnt;
        @(negedge clk);
        a_r[k] = a; b_r[k] = b; sm_r[k] = sm; rdy_r[k] = 1'b1;
        @(posedge clk);
        #1 chk({nm, " busy@accept"}, 64'(busy_w[k]), 64'd1);
        @(negedge clk);
        rdy_r[k] = 1'b0; a_r[k] = ~a; b_r[k] = ~b;
        cnt = 0;
        while (1) begin
            @(posedge clk);
            cnt++;
            #1;
            if (done_w[k] === 1'b1 || cnt > 100) break;
            chk({nm, " busy@calc"}, 64'(busy_w[k]), 64'd1);
        end
        chk({nm, " latency"}, 64'(cnt), 64'(edges));
        chk({nm, " producto"}, 64'(prod_w[k]), 64'(lit));
        if (do_ack) begin
            @(negedge clk);
            ack_r[k] = 1'b1;
            @(posedge clk);
            #1;
            chk({nm, " busy@ack"}, 64'(busy_w[k]), 64'd0);
            chk({nm, " held@ack"}, 64'(prod_w[k]), 64'(lit));
            @(negedge clk);
            ack_r[k] = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            a_r[k] = '0; b_r[k] = '0; sm_r[k] = 1'b0; rdy_r[k] = 1'b0; ack_r[k] = 1'b0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("reset busy", 64'(busy_w[0]), 64'd0);
        chk("reset done", 64'(done_w[0]), 64'd0);
        chk("reset producto", 64'(prod_w[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;

        run_op(0, 16'd16, 16'd31, 1'b0, 32'd496, 16, "unsigned", 1'b1);
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16, "umax", 1'b1);
        run_op(0, 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1, 16, "signed", 1'b1);
        run_op(0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 16, "smin", 1'b1);
        run_op(0, 16'd0, 16'hFFFB, 1'b1, 32'd0, 16, "szero", 1'b1);

        // Handshake: result held while ack stays low, ready toggling ignored.
        run_op(0, 16'd100, 16'd200, 1'b0, 32'd20000, 16, "hs", 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy_r[0] = i[0]; a_r[0] = 16'(i); b_r[0] = 16'(i + 3);
        end
        #1;
        chk("hs done held", 64'(done_w[0]), 64'd1);
        chk("hs producto held", 64'(prod_w[0]), 64'd20000);
        @(negedge clk);
        a_r[0] = 16'd3; b_r[0] = 16'd9; rdy_r[0] = 1'b1; ack_r[0] = 1'b1;
        @(posedge clk);
        #1 chk("hs ack wins", 64'(busy_w[0]), 64'd0);
        @(negedge clk);
        ack_r[0] = 1'b0;
        @(posedge clk);
        #1 chk("hs accept next", 64'(busy_w[0]), 64'd1);
        @(negedge clk);
        rdy_r[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("hs second result", 64'(prod_w[0]), 64'd27);
        ack_r[0] = 1'b1;
        @(negedge clk);
        ack_r[0] = 1'b0;

        // Asynchronous abort mid-calculation.
        @(negedge clk);
        a_r[0] = 16'd16; b_r[0] = 16'd31; sm_r[0] = 1'b0; rdy_r[0] = 1'b1;
        @(posedge clk);
        #1 rdy_r[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort busy", 64'(busy_w[0]), 64'd0);
        chk("abort done", 64'(done_w[0]), 64'd0);
        chk("abort producto", 64'(prod_w[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(0, 16'd1234, 16'd56, 1'b0, 32'd69104, 16, "after abort", 1'b1);

        // Early-exit instance.
        run_op(1, 16'd7, 16'd1, 1'b0, 32'd7, 1, "ee b1", 1'b1);
        run_op(1, 16'd1234, 16'd0, 1'b0, 32'd0, 1, "ee b0", 1'b1);
        run_op(1, 16'd7, 16'h0100, 1'b0, 32'd1792, 9, "ee b256", 1'b1);
        run_op(1, 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1, 3, "ee signed", 1'b1);
        run_op(1, 16'd9, 16'hFFFF, 1'b1, 32'hFFFFFFF7, 1, "ee neg1", 1'b1);
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16, "ee umax", 1'b1);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
